// File: rtl/axi4_slave_burst_wrapper.sv
// AXI4 slave register-file wrapper around a compute core.
// Exposes NIN operand words (R/W), NOUT result words (RO) and one CTRL word
// through INCR bursts of DSZ-bit beats. Independent write and read engines.
module axi4_slave_burst_wrapper #(
  parameter int SZ   = 32,
  parameter int DSZ  = 8,
  parameter int NIN  = 2,
  parameter int NOUT = 2,
  parameter int ASZ  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ASZ-1:0]      awaddr,
  input  logic [7:0]          awlen,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DSZ-1:0]      wdata,
  input  logic                wvalid,
  output logic                wready,
  input  logic                wlast,
  output logic                bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ASZ-1:0]      araddr,
  input  logic [7:0]          arlen,
  input  logic                arvalid,
  output logic                arready,
  output logic [DSZ-1:0]      rdata,
  output logic                rvalid,
  input  logic                rready,
  output logic                rlast,
  output logic                rresp,
  output logic [NIN*SZ-1:0]   core_a,
  output logic                core_start,
  input  logic                core_ready,
  input  logic [NOUT*SZ-1:0]  core_res
);

  localparam int BPW = SZ / DSZ;
  // Lane counters must hold the highest start lane plus 255 increments.
  localparam int LW  = ASZ + $clog2(BPW) + 10;
  localparam logic [LW-1:0] OPR_END   = LW'(NIN * BPW);
  localparam logic [LW-1:0] CTRL_LANE = LW'((NIN + NOUT) * BPW);
  localparam logic [LW-1:0] LANE_END  = LW'((NIN + NOUT + 1) * BPW);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t              w_state_q, w_state_d;
  r_state_t              r_state_q, r_state_d;
  logic [LW-1:0]         wlane_q, wlane_d;
  logic [7:0]            wbeat_q, wbeat_d;
  logic [7:0]            wlen_q, wlen_d;
  logic                  err_q, err_d;
  logic                  bresp_q, bresp_d;
  logic [NIN*SZ-1:0]     opr_q, opr_d;
  logic [NOUT*SZ-1:0]    res_q, res_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  core_start_q, core_start_d;
  logic [LW-1:0]         rlane_q, rlane_d;
  logic [7:0]            rrem_q, rrem_d;
  logic [DSZ-1:0]        rdata_q, rdata_d;
  logic                  rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  beat_err, start_hit;
  logic [LW-1:0]         rd_sel;
  logic [DSZ-1:0]        rd_data;
  logic                  rd_ok;

  assign aw_hs = (w_state_q == W_IDLE) && awvalid;
  assign w_hs  = (w_state_q == W_DATA) && wvalid;
  assign b_hs  = (w_state_q == W_RESP) && bready;
  assign ar_hs = (r_state_q == R_IDLE) && arvalid;
  assign r_hs  = (r_state_q == R_DATA) && rready;

  // State register: every flop of both engines and the control block
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      wlane_q      <= '0;
      wbeat_q      <= '0;
      wlen_q       <= '0;
      err_q        <= 1'b0;
      bresp_q      <= 1'b0;
      opr_q        <= '0;
      res_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      rlane_q      <= '0;
      rrem_q       <= '0;
      rdata_q      <= '0;
      rresp_q      <= 1'b0;
      rlast_q      <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      wlane_q      <= wlane_d;
      wbeat_q      <= wbeat_d;
      wlen_q       <= wlen_d;
      err_q        <= err_d;
      bresp_q      <= bresp_d;
      opr_q        <= opr_d;
      res_q        <= res_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      rlane_q      <= rlane_d;
      rrem_q       <= rrem_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rlast_q      <= rlast_d;
    end
  end

  // Next-state logic for the write and read engines
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (awvalid) w_state_d = W_DATA;
      W_DATA:  if (wvalid && wlast) w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    r_state_d = r_state_q;
    if (r_state_q == R_IDLE) begin
      if (arvalid) r_state_d = R_DATA;
    end else begin
      if (rready && rlast_q) r_state_d = R_IDLE;
    end
  end

  // Handshake outputs decoded from the current states
  always_comb begin
    awready    = (w_state_q == W_IDLE);
    wready     = (w_state_q == W_DATA);
    bvalid     = (w_state_q == W_RESP);
    arready    = (r_state_q == R_IDLE);
    rvalid     = (r_state_q == R_DATA);
    bresp      = bresp_q;
    rdata      = rdata_q;
    rresp      = rresp_q;
    rlast      = rlast_q;
    core_start = core_start_q;
    core_a     = opr_q;
  end

  // Write datapath: lane tracking, operand writes, error and start detection
  always_comb begin
    wlane_d      = wlane_q;
    wbeat_d      = wbeat_q;
    wlen_d       = wlen_q;
    err_d        = err_q;
    bresp_d      = bresp_q;
    opr_d        = opr_q;
    res_d        = res_q;
    busy_d       = busy_q;
    done_d       = done_q;
    core_start_d = 1'b0;
    beat_err     = 1'b0;
    start_hit    = 1'b0;
    if (aw_hs) begin
      wlane_d = LW'(awaddr) * LW'(BPW);
      wbeat_d = '0;
      wlen_d  = awlen;
      err_d   = 1'b0;
    end
    if (w_hs) begin
      wlane_d = wlane_q + LW'(1);
      wbeat_d = wbeat_q + 8'd1;
      if (wlane_q < OPR_END) begin
        for (int i = 0; i < NIN * BPW; i++) begin
          if (wlane_q == LW'(i)) opr_d[i*DSZ +: DSZ] = wdata;
        end
      end else if (wlane_q == CTRL_LANE) begin
        // A start request while the core is busy is silently ignored
        if (wdata[0] && !busy_q) start_hit = 1'b1;
      end else if (wlane_q < CTRL_LANE || wlane_q >= LANE_END) begin
        beat_err = 1'b1;
      end
      // wlast must coincide exactly with the beat announced by awlen
      if (wlast != (wbeat_q == wlen_q)) beat_err = 1'b1;
      err_d = err_q | beat_err;
      if (wlast) bresp_d = ~(err_q | beat_err);
    end
    if (b_hs) err_d = 1'b0;
    if (start_hit) begin
      core_start_d = 1'b1;
      busy_d       = 1'b1;
      done_d       = 1'b0;
    end else if (busy_q && core_ready) begin
      res_d  = core_res;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  // Read lane mux: first lane on address handshake, else the following lane
  always_comb begin
    rd_sel  = ar_hs ? LW'(araddr) * LW'(BPW) : rlane_q + LW'(1);
    rd_data = '0;
    rd_ok   = 1'b0;
    if (rd_sel < OPR_END) begin
      rd_ok = 1'b1;
      for (int i = 0; i < NIN * BPW; i++) begin
        if (rd_sel == LW'(i)) rd_data = opr_q[i*DSZ +: DSZ];
      end
    end else if (rd_sel < CTRL_LANE) begin
      rd_ok = 1'b1;
      for (int i = 0; i < NOUT * BPW; i++) begin
        if (rd_sel == LW'(NIN * BPW + i)) rd_data = res_q[i*DSZ +: DSZ];
      end
    end else if (rd_sel == CTRL_LANE) begin
      rd_ok      = 1'b1;
      rd_data[0] = busy_q;
      rd_data[1] = done_q;
    end else if (rd_sel < LANE_END) begin
      rd_ok = 1'b1;
    end
  end

  // Read datapath: load a beat on address accept and on every accepted beat
  always_comb begin
    rlane_d = rlane_q;
    rrem_d  = rrem_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    if (ar_hs) begin
      rlane_d = rd_sel;
      rrem_d  = arlen;
      rdata_d = rd_data;
      rresp_d = rd_ok;
      rlast_d = (arlen == 8'd0);
    end else if (r_hs) begin
      if (rlast_q) begin
        rlast_d = 1'b0;
      end else begin
        rlane_d = rd_sel;
        rrem_d  = rrem_q - 8'd1;
        rdata_d = rd_data;
        rresp_d = rd_ok;
        rlast_d = (rrem_q == 8'd1);
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_burst_wrapper.sv
// Directed bench for axi4_slave_burst_wrapper with write-response and
// read-beat scoreboards fed from a byte-lane model of the register file.
module tb_axi4_slave_burst_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wdata;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic        bresp;
  logic        bvalid;
  logic        bready;
  logic [2:0]  araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic        rresp;
  logic [63:0] core_a;
  logic        core_start;
  logic        core_ready;
  logic [63:0] core_res;

  always #5 clk = ~clk;

  axi4_slave_burst_wrapper #(.SZ(32), .DSZ(8), .NIN(2), .NOUT(2), .ASZ(3)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
    .core_a(core_a), .core_start(core_start), .core_ready(core_ready),
    .core_res(core_res)
  );

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int s0;
  logic [7:0] model_lane [0:15];
  logic [7:0] model_ctrl;
  logic [7:0] wbuf [0:255];
  logic [9:0] rq [$];
  logic       bq [$];

  // Count cycles with core_start high
  always @(posedge clk) if (core_start === 1'b1) start_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_lane(input int lane);
    if (lane < 16) return {1'b1, model_lane[lane]};
    if (lane == 16) return {1'b1, model_ctrl};
    if (lane < 20) return 9'h100;
    return 9'h000;
  endfunction

  task automatic clear_model();
    foreach (model_lane[i]) model_lane[i] = 8'h00;
    model_ctrl = 8'h00;
  endtask

  task automatic set_results(input logic [63:0] v);
    for (int i = 0; i < 8; i++) model_lane[8+i] = v[i*8 +: 8];
  endtask

  task automatic write_burst(input logic [2:0] addr, input logic [7:0] len,
                             input int nbeats, input int bdelay, input logic exp_ok);
    logic e;
    bq.push_back(exp_ok);
    for (int b = 0; b < nbeats; b++)
      if (int'(addr) * 4 + b < 8) model_lane[int'(addr) * 4 + b] = wbuf[b];
    awaddr = addr; awlen = len; awvalid = 1'b1;
    for (int t = 0; t < 50 && awready !== 1'b1; t++) step();
    chk("aw_wait", awready, 1);
    step();
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wdata = wbuf[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
      for (int t = 0; t < 50 && wready !== 1'b1; t++) step();
      chk("w_wait", wready, 1);
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int c = 0; c < bdelay; c++) begin
      chk("b_hold", bvalid, 1);
      chk("aw_blocked", awready, 0);
      step();
    end
    bready = 1'b1;
    for (int t = 0; t < 50 && bvalid !== 1'b1; t++) step();
    chk("b_wait", bvalid, 1);
    e = bq.pop_front();
    chk("bresp", bresp, e);
    step();
    bready = 1'b0;
    chk("b_single", bvalid, 0);
    chk("aw_back", awready, 1);
  endtask

  task automatic read_burst(input logic [2:0] addr, input logic [7:0] len, input bit toggle);
    int n;
    int got;
    int cyc;
    bit stalled;
    logic [9:0] held;
    logic [9:0] cur;
    logic [9:0] x;
    logic [8:0] e;
    n = int'(len) + 1; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    for (int b = 0; b < n; b++) begin
      e = exp_lane(int'(addr) * 4 + b);
      rq.push_back({e[8], (b == n - 1), e[7:0]});
    end
    araddr = addr; arlen = len; arvalid = 1'b1;
    for (int t = 0; t < 50 && arready !== 1'b1; t++) step();
    chk("ar_wait", arready, 1);
    step();
    arvalid = 1'b0;
    while (got < n && cyc < 2000) begin
      rready = toggle ? (cyc % 2 == 1) : 1'b1;
      cur = {rresp, rlast, rdata};
      if (stalled) chk("r_stable", cur, held);
      stalled = 1'b0;
      if (rvalid === 1'b1) begin
        if (rready) begin
          x = rq.pop_front();
          chk("rdata", rdata, x[7:0]);
          chk("rresp", rresp, x[9]);
          chk("rlast", rlast, x[8]);
          got++;
        end else begin
          stalled = 1'b1;
          held = cur;
        end
      end
      step();
      cyc++;
    end
    rready = 1'b0;
    chk("r_count", got, n);
    chk("r_end_valid", rvalid, 0);
    chk("r_end_arready", arready, 1);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    core_ready = 1'b0; core_res = '0;
    clear_model();
    step(); step();
    rst = 1'b0;
    step();
    // reset state
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_a", core_a, 0);

    // 1: full operand write and read back
    for (int b = 0; b < 8; b++) wbuf[b] = 8'(b + 1);
    write_burst(3'd0, 8'd7, 8, 0, 1'b1);
    chk("core_a_t1", core_a, 64'h0807060504030201);
    read_burst(3'd0, 8'd7, 1'b0);

    // 2: start, busy, core completion, results
    s0 = start_cnt;
    wbuf[0] = 8'h01;
    write_burst(3'd4, 8'd0, 1, 0, 1'b1);
    model_ctrl = 8'h01;
    read_burst(3'd4, 8'd0, 1'b0);
    chk("start_pulse", start_cnt - s0, 1);
    core_res = 64'h1122334455667788; core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    set_results(64'h1122334455667788);
    model_ctrl = 8'h02;
    read_burst(3'd4, 8'd0, 1'b0);
    read_burst(3'd2, 8'd7, 1'b0);
    // core_ready while idle must not disturb results
    core_res = 64'hdeadbeefcafef00d; core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    read_burst(3'd2, 8'd7, 1'b0);

    // 3: out-of-range and read-only writes
    for (int b = 0; b < 4; b++) wbuf[b] = 8'(8'hA0 + b);
    write_burst(3'd5, 8'd0, 1, 0, 1'b0);
    write_burst(3'd2, 8'd3, 4, 0, 1'b0);
    chk("core_a_t3", core_a, 64'h0807060504030201);
    read_burst(3'd0, 8'd7, 1'b0);
    read_burst(3'd2, 8'd7, 1'b0);
    read_burst(3'd4, 8'd7, 1'b0);
    read_burst(3'd5, 8'd0, 1'b0);

    // 4: read and write-response backpressure
    read_burst(3'd0, 8'd7, 1'b1);
    for (int b = 0; b < 4; b++) wbuf[b] = 8'(8'hA1 + b);
    write_burst(3'd1, 8'd3, 4, 3, 1'b1);
    chk("core_a_t4", core_a, 64'hA4A3A2A104030201);

    // 6: start while busy is ignored; early wlast flags error
    s0 = start_cnt;
    wbuf[0] = 8'h01;
    write_burst(3'd4, 8'd0, 1, 0, 1'b1);
    model_ctrl = 8'h01;
    write_burst(3'd4, 8'd0, 1, 0, 1'b1);
    step();
    chk("start_while_busy", start_cnt - s0, 1);
    read_burst(3'd4, 8'd0, 1'b0);
    core_res = 64'h0123456789abcdef; core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    set_results(64'h0123456789abcdef);
    model_ctrl = 8'h02;
    read_burst(3'd2, 8'd7, 1'b0);
    read_burst(3'd4, 8'd0, 1'b0);
    wbuf[0] = 8'h31; wbuf[1] = 8'h32; wbuf[2] = 8'h33;
    write_burst(3'd0, 8'd3, 3, 0, 1'b0);
    chk("core_a_t6", core_a, 64'hA4A3A2A104333231);

    // 5: reset in the middle of a write burst
    for (int b = 0; b < 8; b++) wbuf[b] = 8'(8'h50 + b);
    awaddr = 3'd0; awlen = 8'd7; awvalid = 1'b1;
    for (int t = 0; t < 50 && awready !== 1'b1; t++) step();
    chk("t5_aw_wait", awready, 1);
    step();
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wdata = wbuf[b]; wlast = 1'b0; wvalid = 1'b1;
      for (int t = 0; t < 50 && wready !== 1'b1; t++) step();
      chk("t5_w_wait", wready, 1);
      step();
    end
    wvalid = 1'b0;
    rst = 1'b1;
    step();
    chk("t5_awready", awready, 1);
    chk("t5_wready", wready, 0);
    chk("t5_bvalid", bvalid, 0);
    chk("t5_core_a", core_a, 0);
    rst = 1'b0;
    clear_model();
    step();
    read_burst(3'd0, 8'd7, 1'b0);
    read_burst(3'd2, 8'd7, 1'b0);
    read_burst(3'd4, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
